multi_cycle_ctrl: RTL and testbench
===================================

# multi_cycle_ctrl

Multi-cycle RV32I control unit. It replaces the single-cycle, R-type-only decoder with a state machine that sequences fetch, decode, execute, memory and writeback. It drives PC/IR load enables, ALU and operand selects, register-file write controls and data-memory strobes, and handshakes with instruction and data memories that can stall. It sits between the IR/PC datapath registers and the ALU, register file and memory ports of the multi-cycle core.

## Interface
Parameters:
- INSTRUCTION_WIDTH, 32: IR width. Only bits [31:0] are decoded.
- ALU_CTRL_WIDTH, 4: alu_ctrl width, must be ≥4. Bits above [3] are always 0.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- inst  in  INSTRUCTION_WIDTH  current IR contents
- imem_ready  in  1  instruction memory data valid this cycle
- dmem_ready  in  1  data memory access completes this cycle
- alu_cmp  in  1  branch condition from the datapath comparator (funct3-evaluated); 1 = taken
- imem_rd_en  out  1  instruction read request
- ir_wr_en  out  1  load IR
- pc_wr_en  out  1  load PC
- pc_src_sel  out  2  00 = PC+4, 01 = PC+imm, 10 = ALU result register
- alu_ctrl  out  ALU_CTRL_WIDTH  ALU operation
- alu_op1_sel  out  2  00 = rs1, 01 = PC, 10 = zero
- alu_op2_sel  out  1  0 = rs2, 1 = immediate
- imm_sel  out  3  000 = I, 001 = S, 010 = B, 011 = U, 100 = J
- reg_file_wr_en  out  1  register write
- reg_file_wr_back_sel  out  2  00 = ALU result, 01 = load data, 10 = PC+4
- data_mem_rd_en  out  1  load strobe
- data_mem_wr_en  out  1  store strobe
- illegal_inst  out  1  sticky illegal-instruction flag

## Operation
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, and TRAP (TRAP exists only with the configuration macro).
- FETCH:
  - imem_rd_en = 1, held until imem_ready.
  - In the imem_ready cycle, ir_wr_en = 1 and the FSM moves to DECODE.
- DECODE:
  - One cycle.
  - Legal means inst[1:0] = 11 and inst[6:2] is one of: R 01100, OP-IMM 00100, LOAD 00000, STORE 01000, BRANCH 11000, LUI 01101, AUIPC 00101, JAL 11011, JALR 11001.
  - Legal → EXECUTE. Illegal: see Configuration.
- EXECUTE per class:
  - R: alu_ctrl = {inst[30], inst[14:12]}, op1 = rs1, op2 = rs2 → WRITEBACK.
  - OP-IMM: alu_ctrl = {(funct3 == 101) & inst[30], funct3}, op2 = imm, imm_sel = I → WRITEBACK.
  - LOAD / STORE: ADD (0000), op2 = imm, imm_sel = I / S → MEM.
  - LUI: op1 = zero, op2 = imm, imm_sel = U, ADD → WRITEBACK.
  - AUIPC: op1 = PC, imm U, ADD → WRITEBACK.
  - JAL: op1 = PC, imm J, ADD → WRITEBACK.
  - JALR: op1 = rs1, imm I, ADD → WRITEBACK.
  - BRANCH: alu_ctrl = SUB (1000), imm_sel = B, pc_wr_en = 1, pc_src_sel = alu_cmp ? 01 : 00 → FETCH.
- MEM:
  - LOAD: data_mem_rd_en held until dmem_ready, then → WRITEBACK.
  - STORE: data_mem_wr_en held until dmem_ready. In the ready cycle pc_wr_en = 1 and pc_src_sel = 00 → FETCH.
- WRITEBACK:
  - reg_file_wr_en = 1; rd = x0 is not filtered.
  - pc_wr_en = 1.
  - wr_back_sel: 01 for LOAD, 10 for JAL/JALR, else 00.
  - pc_src_sel: 10 for JAL/JALR, else 00.
  - → FETCH.
- Outputs not listed for a state are 0.

## Timing
- Reset:
  - While rst = 1, every output is 0 and state is forced to FETCH.
  - Outputs are combinational from state and inst, gated by rst.
  - The first imem_rd_en appears in the cycle after rst deasserts.
- rst asserted mid-instruction: strobes drop in the same cycle, no PC/register write occurs, and the FSM restarts at FETCH.
- Latency with zero-wait memories: R/OP-IMM/LUI/AUIPC/JAL/JALR 4 cycles, LOAD 5, STORE 4, BRANCH 3.
- Each wait cycle on imem_ready or dmem_ready adds exactly one cycle. Strobes stay asserted and stable while waiting.
- Exactly one pc_wr_en pulse per retired instruction. ir_wr_en is asserted only in the FETCH ready cycle.
- inst must be stable from DECODE until the instruction's final state.

## Configuration
- ILLEGAL_TRAP_EN defined:
  - An illegal instruction in DECODE → TRAP.
  - In TRAP, illegal_inst = 1 and all other outputs are 0.
  - TRAP is held until rst.
- ILLEGAL_TRAP_EN undefined:
  - An illegal instruction is a NOP: in DECODE, pc_wr_en = 1 and pc_src_sel = 00 → FETCH (2-cycle instruction).
  - illegal_inst is tied to 0 and the TRAP state is not built.

## Test plan
- Reset, then R-type ADD 0x00208033 with imem_ready = 1 → imem_rd_en in cycle 1, alu_ctrl = 0000 in EXECUTE, reg_file_wr_en and pc_wr_en = 1 in cycle 4 with wr_back_sel = 00.
- SUB 0x40208033, then SRAI 0x4030D093 → alu_ctrl = 1000, then 1101 with alu_op2_sel = 1.
- LW 0x0000A103 with dmem_ready low for 3 cycles → data_mem_rd_en held 4 cycles, WRITEBACK with wr_back_sel = 01, 8 cycles total.
- BEQ 0x00208463 with alu_cmp = 1, then = 0 → 3-cycle instructions, pc_src_sel = 01, then 00.
- JAL 0x008000EF → op1 = PC, imm_sel = 100, WRITEBACK with wr_back_sel = 10 and pc_src_sel = 10.
- Illegal 0x00000000 → with ILLEGAL_TRAP_EN: illegal_inst = 1 persists until rst. Without it: pc_wr_en pulse in DECODE, then FETCH. rst during a stalled store → data_mem_wr_en = 0 in the same cycle.

Source files
------------

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK
// with stallable memories. Define ILLEGAL_TRAP_EN to trap on illegal opcodes.
module multi_cycle_ctrl #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int ALU_CTRL_WIDTH    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [INSTRUCTION_WIDTH-1:0] inst,
  input  logic                         imem_ready,
  input  logic                         dmem_ready,
  input  logic                         alu_cmp,
  output logic                         imem_rd_en,
  output logic                         ir_wr_en,
  output logic                         pc_wr_en,
  output logic [1:0]                   pc_src_sel,
  output logic [ALU_CTRL_WIDTH-1:0]    alu_ctrl,
  output logic [1:0]                   alu_op1_sel,
  output logic                         alu_op2_sel,
  output logic [2:0]                   imm_sel,
  output logic                         reg_file_wr_en,
  output logic [1:0]                   reg_file_wr_back_sel,
  output logic                         data_mem_rd_en,
  output logic                         data_mem_wr_en,
  output logic                         illegal_inst
);

  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  localparam logic [1:0] OP1_RS1  = 2'b00;
  localparam logic [1:0] OP1_PC   = 2'b01;
  localparam logic [1:0] OP1_ZERO = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_IMM   = 2'b01;
  localparam logic [1:0] PC_ALU   = 2'b10;

  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEM,
    S_WRITEBACK
`ifdef ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;

  typedef struct packed {
    logic       imem_rd;
    logic       ir_wr;
    logic       pc_wr;
    logic [1:0] pc_src;
    logic [3:0] alu;
    logic [1:0] op1;
    logic       op2;
    logic [2:0] imm;
    logic       rf_wr;
    logic [1:0] wb_sel;
    logic       dm_rd;
    logic       dm_wr;
    logic       ill;
  } ctrl_t;

  state_t state;
  ctrl_t  ctrl, ctrl_q;

  logic [4:0] opc;
  logic [2:0] funct3;
  logic       is_r, is_imm, is_load, is_store, is_branch;
  logic       is_lui, is_auipc, is_jal, is_jalr, is_jump, legal;

  // Fields outside opcode/funct3/bit30 are datapath-only.
  logic unused_inst;
  assign unused_inst = ^inst;

  assign opc       = inst[6:2];
  assign funct3    = inst[14:12];
  assign is_r      = (opc == OP_R);
  assign is_imm    = (opc == OP_IMM);
  assign is_load   = (opc == OP_LOAD);
  assign is_store  = (opc == OP_STORE);
  assign is_branch = (opc == OP_BRANCH);
  assign is_lui    = (opc == OP_LUI);
  assign is_auipc  = (opc == OP_AUIPC);
  assign is_jal    = (opc == OP_JAL);
  assign is_jalr   = (opc == OP_JALR);
  assign is_jump   = is_jal | is_jalr;
  assign legal     = (inst[1:0] == 2'b11) &
                     (is_r | is_imm | is_load | is_store | is_branch |
                      is_lui | is_auipc | is_jal | is_jalr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:     if (imem_ready) state <= S_DECODE;
        S_DECODE: begin
          if (legal)
            state <= S_EXECUTE;
          else
`ifdef ILLEGAL_TRAP_EN
            state <= S_TRAP;
`else
            state <= S_FETCH;
`endif
        end
        S_EXECUTE: begin
          if (is_load | is_store) state <= S_MEM;
          else if (is_branch)     state <= S_FETCH;
          else                    state <= S_WRITEBACK;
        end
        S_MEM:       if (dmem_ready) state <= is_load ? S_WRITEBACK : S_FETCH;
        S_WRITEBACK: state <= S_FETCH;
`ifdef ILLEGAL_TRAP_EN
        S_TRAP:      state <= S_TRAP;
`endif
        default:     state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.imem_rd = 1'b1;
        ctrl.ir_wr   = imem_ready;
      end
      S_DECODE: begin
`ifndef ILLEGAL_TRAP_EN
        // Illegal opcode retires as a NOP straight out of decode.
        ctrl.pc_wr  = ~legal;
        ctrl.pc_src = PC_PLUS4;
`endif
      end
      S_EXECUTE: begin
        if (is_r) begin
          ctrl.alu = {inst[30], funct3};
        end else if (is_imm) begin
          // Bit 30 only selects SRA vs SRL; elsewhere it is immediate data.
          ctrl.alu = {(funct3 == 3'b101) & inst[30], funct3};
          ctrl.op2 = 1'b1;
          ctrl.imm = IMM_I;
        end else if (is_load | is_store) begin
          ctrl.alu = ALU_ADD;
          ctrl.op2 = 1'b1;
          ctrl.imm = is_store ? IMM_S : IMM_I;
        end else if (is_lui) begin
          ctrl.op1 = OP1_ZERO;
          ctrl.op2 = 1'b1;
          ctrl.imm = IMM_U;
        end else if (is_auipc | is_jal) begin
          ctrl.op1 = OP1_PC;
          ctrl.op2 = 1'b1;
          ctrl.imm = is_jal ? IMM_J : IMM_U;
        end else if (is_jalr) begin
          ctrl.op1 = OP1_RS1;
          ctrl.op2 = 1'b1;
          ctrl.imm = IMM_I;
        end else if (is_branch) begin
          ctrl.alu    = ALU_SUB;
          ctrl.imm    = IMM_B;
          ctrl.pc_wr  = 1'b1;
          ctrl.pc_src = alu_cmp ? PC_IMM : PC_PLUS4;
        end
      end
      S_MEM: begin
        ctrl.dm_rd  = is_load;
        ctrl.dm_wr  = is_store;
        ctrl.pc_wr  = is_store & dmem_ready;
        ctrl.pc_src = PC_PLUS4;
      end
      S_WRITEBACK: begin
        ctrl.rf_wr  = 1'b1;
        ctrl.pc_wr  = 1'b1;
        ctrl.wb_sel = is_load ? WB_LOAD : (is_jump ? WB_PC4 : WB_ALU);
        ctrl.pc_src = is_jump ? PC_ALU : PC_PLUS4;
      end
`ifdef ILLEGAL_TRAP_EN
      S_TRAP:  ctrl.ill = 1'b1;
`endif
      default: ctrl = '0;
    endcase
  end

  // Reset kills every strobe in the same cycle, including a stalled access.
  assign ctrl_q = rst ? '0 : ctrl;

  assign imem_rd_en           = ctrl_q.imem_rd;
  assign ir_wr_en             = ctrl_q.ir_wr;
  assign pc_wr_en             = ctrl_q.pc_wr;
  assign pc_src_sel           = ctrl_q.pc_src;
  assign alu_op1_sel          = ctrl_q.op1;
  assign alu_op2_sel          = ctrl_q.op2;
  assign imm_sel              = ctrl_q.imm;
  assign reg_file_wr_en       = ctrl_q.rf_wr;
  assign reg_file_wr_back_sel = ctrl_q.wb_sel;
  assign data_mem_rd_en       = ctrl_q.dm_rd;
  assign data_mem_wr_en       = ctrl_q.dm_wr;
  assign illegal_inst         = ctrl_q.ill;

  always_comb begin
    alu_ctrl      = '0;
    alu_ctrl[3:0] = ctrl_q.alu;
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed per-cycle vector bench for multi_cycle_ctrl; expected control words
// are hand-written per state and instruction class.
module tb_multi_cycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst = '0;
  logic        imem_ready = 1'b0, dmem_ready = 1'b0, alu_cmp = 1'b0;
  logic        imem_rd_en, ir_wr_en, pc_wr_en, alu_op2_sel, reg_file_wr_en;
  logic        data_mem_rd_en, data_mem_wr_en, illegal_inst;
  logic [1:0]  pc_src_sel, alu_op1_sel, reg_file_wr_back_sel;
  logic [3:0]  alu_ctrl;
  logic [2:0]  imm_sel;

  int checks = 0;
  int errors = 0;

  multi_cycle_ctrl #(.INSTRUCTION_WIDTH(32), .ALU_CTRL_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .inst(inst),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .alu_cmp(alu_cmp),
    .imem_rd_en(imem_rd_en), .ir_wr_en(ir_wr_en), .pc_wr_en(pc_wr_en),
    .pc_src_sel(pc_src_sel), .alu_ctrl(alu_ctrl), .alu_op1_sel(alu_op1_sel),
    .alu_op2_sel(alu_op2_sel), .imm_sel(imm_sel),
    .reg_file_wr_en(reg_file_wr_en), .reg_file_wr_back_sel(reg_file_wr_back_sel),
    .data_mem_rd_en(data_mem_rd_en), .data_mem_wr_en(data_mem_wr_en),
    .illegal_inst(illegal_inst)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic [31:0] inst;
    logic        ir, dr, cmp;
    logic [20:0] exp;
  } vec_t;

  vec_t tbl[$];

  // Word layout: rd,irw,pcw,src[2],alu[4],op1[2],op2,imm[3],rfw,wb[2],drd,dwr,ill
  function automatic logic [20:0] e(input logic rd, irw, pcw, input logic [1:0] src,
                                    input logic [3:0] alu, input logic [1:0] o1,
                                    input logic o2, input logic [2:0] imm, input logic rfw,
                                    input logic [1:0] wb, input logic drd, dwr, ill);
    return {rd, irw, pcw, src, alu, o1, o2, imm, rfw, wb, drd, dwr, ill};
  endfunction

  function automatic logic [20:0] f_rdy();  return e(1,1,0,0,0,0,0,0,0,0,0,0,0); endfunction
  function automatic logic [20:0] f_wait(); return e(1,0,0,0,0,0,0,0,0,0,0,0,0); endfunction
  function automatic logic [20:0] zero();   return '0; endfunction
  function automatic logic [20:0] ex(input logic [3:0] a, input logic [1:0] o1,
                                     input logic o2, input logic [2:0] imm);
    return e(0,0,0,0,a,o1,o2,imm,0,0,0,0,0);
  endfunction
  function automatic logic [20:0] wbk(input logic [1:0] wb, input logic [1:0] src);
    return e(0,0,1,src,0,0,0,0,1,wb,0,0,0);
  endfunction

  task automatic add(input string n, input logic r, input logic [31:0] i,
                     input logic ir, input logic dr, input logic cmp, input logic [20:0] x);
    tbl.push_back('{n, r, i, ir, dr, cmp, x});
  endtask

  // Zero-wait four-state instruction: FETCH, DECODE, EXECUTE, WRITEBACK.
  task automatic add4(input string n, input logic [31:0] i, input logic [20:0] exe,
                      input logic [1:0] wb, input logic [1:0] src);
    add({n, ".f"}, 0, i, 1, 1, 0, f_rdy());
    add({n, ".d"}, 0, i, 1, 1, 0, zero());
    add({n, ".e"}, 0, i, 1, 1, 0, exe);
    add({n, ".w"}, 0, i, 1, 1, 0, wbk(wb, src));
  endtask

  function automatic logic [20:0] actual();
    return {imem_rd_en, ir_wr_en, pc_wr_en, pc_src_sel, alu_ctrl, alu_op1_sel,
            alu_op2_sel, imm_sel, reg_file_wr_en, reg_file_wr_back_sel,
            data_mem_rd_en, data_mem_wr_en, illegal_inst};
  endfunction

  task automatic step(input string n, input logic r, input logic [31:0] i,
                      input logic ir, input logic dr, input logic cmp, input logic [20:0] x);
    logic [20:0] got;
    @(negedge clk);
    rst = r; inst = i; imem_ready = ir; dmem_ready = dr; alu_cmp = cmp;
    #1;
    got = actual();
    checks++;
    if (got !== x) begin
      errors++;
      $display("FAIL %s got %h want %h", n, got, x);
    end
  endtask

  initial begin
    add("reset", 1, 32'h00208033, 1, 1, 1, zero());
    // ADD, then back-to-back SUB and SRAI.
    add4("add",  32'h00208033, ex(4'b0000, 2'b00, 0, 3'b000), 2'b00, 2'b00);
    add4("sub",  32'h40208033, ex(4'b1000, 2'b00, 0, 3'b000), 2'b00, 2'b00);
    add4("srai", 32'h4030D093, ex(4'b1101, 2'b00, 1, 3'b000), 2'b00, 2'b00);
    // ADDI with imm bit 30 set must not turn into a subtract.
    add4("addi", 32'h40000093, ex(4'b0000, 2'b00, 1, 3'b000), 2'b00, 2'b00);
    // LW with three dmem wait cycles: eight cycles total.
    add("lw.f",  0, 32'h0000A103, 1, 0, 0, f_rdy());
    add("lw.d",  0, 32'h0000A103, 1, 0, 0, zero());
    add("lw.e",  0, 32'h0000A103, 1, 0, 0, ex(4'b0000, 2'b00, 1, 3'b000));
    add("lw.m0", 0, 32'h0000A103, 1, 0, 0, e(0,0,0,0,0,0,0,0,0,0,1,0,0));
    add("lw.m1", 0, 32'h0000A103, 1, 0, 0, e(0,0,0,0,0,0,0,0,0,0,1,0,0));
    add("lw.m2", 0, 32'h0000A103, 1, 0, 0, e(0,0,0,0,0,0,0,0,0,0,1,0,0));
    add("lw.m3", 0, 32'h0000A103, 1, 1, 0, e(0,0,0,0,0,0,0,0,0,0,1,0,0));
    add("lw.w",  0, 32'h0000A103, 1, 0, 0, wbk(2'b01, 2'b00));
    // BEQ taken then not taken, three cycles each.
    add("beq1.f", 0, 32'h00208463, 1, 0, 1, f_rdy());
    add("beq1.d", 0, 32'h00208463, 1, 0, 1, zero());
    add("beq1.e", 0, 32'h00208463, 1, 0, 1, e(0,0,1,2'b01,4'b1000,0,0,3'b010,0,0,0,0,0));
    add("beq0.f", 0, 32'h00208463, 1, 0, 0, f_rdy());
    add("beq0.d", 0, 32'h00208463, 1, 0, 0, zero());
    add("beq0.e", 0, 32'h00208463, 1, 0, 0, e(0,0,1,2'b00,4'b1000,0,0,3'b010,0,0,0,0,0));
    add4("jal",   32'h008000EF, ex(4'b0000, 2'b01, 1, 3'b100), 2'b10, 2'b10);
    add4("jalr",  32'h000080E7, ex(4'b0000, 2'b00, 1, 3'b000), 2'b10, 2'b10);
    add4("lui",   32'h123450B7, ex(4'b0000, 2'b10, 1, 3'b011), 2'b00, 2'b00);
    add4("auipc", 32'h00001097, ex(4'b0000, 2'b01, 1, 3'b011), 2'b00, 2'b00);
    // SW after one imem wait and one dmem wait.
    add("sw.fw", 0, 32'h0020A023, 0, 0, 0, f_wait());
    add("sw.f",  0, 32'h0020A023, 1, 0, 0, f_rdy());
    add("sw.d",  0, 32'h0020A023, 1, 0, 0, zero());
    add("sw.e",  0, 32'h0020A023, 1, 0, 0, ex(4'b0000, 2'b00, 1, 3'b001));
    add("sw.m0", 0, 32'h0020A023, 1, 0, 0, e(0,0,0,0,0,0,0,0,0,0,0,1,0));
    add("sw.m1", 0, 32'h0020A023, 1, 1, 0, e(0,0,1,0,0,0,0,0,0,0,0,1,0));
    // Reset during a stalled store kills the strobe and any PC write.
    add("swr.f",  0, 32'h0020A023, 1, 0, 0, f_rdy());
    add("swr.d",  0, 32'h0020A023, 1, 0, 0, zero());
    add("swr.e",  0, 32'h0020A023, 1, 0, 0, ex(4'b0000, 2'b00, 1, 3'b001));
    add("swr.m",  0, 32'h0020A023, 1, 0, 0, e(0,0,0,0,0,0,0,0,0,0,0,1,0));
    add("swr.rst",1, 32'h0020A023, 1, 1, 0, zero());
    add("swr.f2", 0, 32'h0020A023, 0, 0, 0, f_wait());

    foreach (tbl[k]) step(tbl[k].name, tbl[k].rst, tbl[k].inst, tbl[k].ir,
                          tbl[k].dr, tbl[k].cmp, tbl[k].exp);

    // Illegal opcodes, then recovery with a legal R-type.
    step("ill.f", 0, 32'h00000000, 1, 0, 0, f_rdy());
`ifdef ILLEGAL_TRAP_EN
    step("ill.d",  0, 32'h00000000, 1, 0, 0, zero());
    for (int t = 0; t < 3; t++)
      step("ill.trap", 0, 32'h00208033, 1, 1, 1, e(0,0,0,0,0,0,0,0,0,0,0,0,1));
    step("ill.rst", 1, 32'h00208033, 1, 1, 1, zero());
`else
    step("ill.d",  0, 32'h00000000, 1, 0, 0, e(0,0,1,0,0,0,0,0,0,0,0,0,0));
    step("ill2.f", 0, 32'h00208030, 1, 0, 0, f_rdy());
    step("ill2.d", 0, 32'h00208030, 1, 0, 0, e(0,0,1,0,0,0,0,0,0,0,0,0,0));
`endif
    step("rec.f", 0, 32'h00208033, 1, 0, 0, f_rdy());
    step("rec.d", 0, 32'h00208033, 1, 0, 0, zero());
    step("rec.e", 0, 32'h00208033, 1, 0, 0, ex(4'b0000, 2'b00, 0, 3'b000));
    step("rec.w", 0, 32'h00208033, 1, 0, 0, wbk(2'b00, 2'b00));
    step("rec.f2",0, 32'h00208033, 0, 0, 0, f_wait());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
